frame_strobe_gen: RTL and testbench

Configuration-frame driver for the fabric's column strobe/data distribution network. It accepts a stream of 32-bit configuration words over a valid/ready handshake. Each frame is assembled from one header word and NumRows data words, then presented on FrameData. A one-hot FrameStrobe pulse is then issued for the addressed column and frame. It sits at the top of each column chain and feeds the terminal tiles that buffer and forward FrameStrobe through the column.

---
 rtl/frame_strobe_gen_if.sv | 9 +
 rtl/frame_strobe_gen.sv | 122 ++++++++++++
 tb/tb_frame_strobe_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_strobe_gen_if.sv
// Configuration word stream into the frame strobe driver: 32-bit word with valid/ready handshake.
interface frame_strobe_gen_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_strobe_gen.sv
// Assembles a header plus NumRows data words into FrameData, then pulses one FrameStrobe line
// for StrobeCycles cycles followed by a one-cycle gap; input is stalled (s_ready low) while strobing.
module frame_strobe_gen #(
  parameter int MaxFramesPerCol = 36,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 4,
  parameter int NumCols         = 8,
  parameter int StrobeCycles    = 2
) (
  input  logic                                CLK,
  input  logic                                reset,
  frame_strobe_gen_if.slave                   cfg,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
  output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                busy,
  output logic                                err_hdr,
  output logic [15:0]                         frames_done
);

  localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int CW = (NumCols > 1) ? $clog2(NumCols) : 1;
  localparam int FW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int NS = NumCols * MaxFramesPerCol;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {HDR, DATA, STROBE, GAP} state_t;

  state_t                                 state;
  logic [NumRows-1:0][FrameBitsPerRow-1:0] rows;
  logic [RW-1:0]                          row_q;
  logic [CW-1:0]                          col_q;
  logic [FW-1:0]                          frame_q;
  logic [3:0]                             scnt;

  logic        accept;
  logic [15:0] hdr_magic;
  logic [7:0]  hdr_col;
  logic [7:0]  hdr_frame;
  logic        hdr_ok;
  logic [IW-1:0] strobe_idx;
  logic [NS-1:0] strobe_onehot;

  assign accept    = cfg.s_valid && cfg.s_ready;
  assign hdr_magic = cfg.s_data[31:16];
  assign hdr_col   = cfg.s_data[15:8];
  assign hdr_frame = cfg.s_data[7:0];
  assign hdr_ok    = (hdr_magic == 16'hFAB0) &&
                     (32'(hdr_col) < NumCols) &&
                     (32'(hdr_frame) < MaxFramesPerCol);

  assign FrameData = rows;

  // Strobe line is decoded from the latched header so the pulse has no path from the input bus.
  always_comb begin
    strobe_idx    = IW'(col_q) * IW'(MaxFramesPerCol) + IW'(frame_q);
    strobe_onehot = '0;
    strobe_onehot[strobe_idx] = 1'b1;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= HDR;
      cfg.s_ready <= 1'b0;
      rows        <= '0;
      FrameStrobe <= '0;
      busy        <= 1'b0;
      err_hdr     <= 1'b0;
      frames_done <= 16'd0;
      row_q       <= '0;
      col_q       <= '0;
      frame_q     <= '0;
      scnt        <= 4'd0;
    end else begin
      err_hdr <= 1'b0;
      case (state)
        HDR: begin
          cfg.s_ready <= 1'b1;
          if (accept) begin
            if (hdr_ok) begin
              col_q   <= CW'(hdr_col);
              frame_q <= FW'(hdr_frame);
              row_q   <= '0;
              busy    <= 1'b1;
              state   <= DATA;
            end else begin
              err_hdr <= 1'b1;
            end
          end
        end
        DATA: begin
          if (accept) begin
            rows[row_q] <= cfg.s_data;
            if (row_q == RW'(NumRows - 1)) begin
              state       <= STROBE;
              cfg.s_ready <= 1'b0;
              FrameStrobe <= strobe_onehot;
              scnt        <= 4'd0;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        STROBE: begin
          if (scnt == 4'(StrobeCycles - 1)) begin
            state       <= GAP;
            FrameStrobe <= '0;
            frames_done <= frames_done + 16'd1;
          end else begin
            scnt <= scnt + 4'd1;
          end
        end
        GAP: begin
          state       <= HDR;
          cfg.s_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_strobe_gen.sv
// Directed bench for frame_strobe_gen: reset, basic frame, bad headers, stalls, reset mid-strobe,
// back-to-back frames and frame counter wrap.
module tb_frame_strobe_gen;

  logic         CLK;
  logic         reset;
  logic [127:0] FrameData;
  logic [287:0] FrameStrobe;
  logic         busy;
  logic         err_hdr;
  logic [15:0]  frames_done;

  int checks = 0;
  int errors = 0;

  frame_strobe_gen_if cfg ();

  frame_strobe_gen dut (
    .CLK         (CLK),
    .reset       (reset),
    .cfg         (cfg),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err_hdr     (err_hdr),
    .frames_done (frames_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [287:0] onehot(input int b);
    logic [287:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    cfg.s_data  = w;
    cfg.s_valid = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0]  bad_hdr [3];
    logic [31:0]  stall_w [4];
    logic [127:0] basic_fd;
    logic [127:0] stall_fd;
    logic [127:0] f1_fd;

    basic_fd = 128'h44444444_33333333_22222222_11111111;
    stall_fd = 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1;
    f1_fd    = 128'h04040404_03030303_02020202_01010101;
    bad_hdr  = '{32'hFAB1_0000, 32'hFAB0_0800, 32'hFAB0_0024};
    stall_w  = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4};

    // Reset state
    reset = 1'b1;
    cfg.s_data = '0;
    cfg.s_valid = 1'b0;
    tick();
    tick();
    check("rst_ready",  cfg.s_ready, 0);
    check("rst_fdata",  FrameData, 0);
    check("rst_strobe", FrameStrobe, 0);
    check("rst_busy",   busy, 0);
    check("rst_err",    err_hdr, 0);
    check("rst_done",   frames_done, 0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", cfg.s_ready, 1);

    // Basic frame to col 2 / frame 3
    send(32'hFAB0_0203);
    check("basic_busy", busy, 1);
    send(32'h11111111);
    send(32'h22222222);
    send(32'h33333333);
    check("basic_no_early_strobe", FrameStrobe, 0);
    send(32'h44444444);
    cfg.s_valid = 1'b0;
    check("basic_strobe0", FrameStrobe, onehot(75));
    check("basic_fdata",   FrameData, basic_fd);
    check("basic_ready0",  cfg.s_ready, 0);
    tick();
    check("basic_strobe1", FrameStrobe, onehot(75));
    check("basic_ready1",  cfg.s_ready, 0);
    tick();
    check("basic_gap_strobe", FrameStrobe, 0);
    check("basic_gap_ready",  cfg.s_ready, 0);
    check("basic_gap_fdata",  FrameData, basic_fd);
    check("basic_done",       frames_done, 1);
    tick();
    check("basic_hdr_ready", cfg.s_ready, 1);
    check("basic_hdr_busy",  busy, 0);

    // Back-to-back bad headers
    for (int i = 0; i < 3; i++) begin
      send(bad_hdr[i]);
      check($sformatf("bad%0d_err", i),    err_hdr, 1);
      check($sformatf("bad%0d_busy", i),   busy, 0);
      check($sformatf("bad%0d_strobe", i), FrameStrobe, 0);
    end
    cfg.s_valid = 1'b0;
    tick();
    check("bad_err_clear", err_hdr, 0);
    check("bad_fdata",     FrameData, basic_fd);
    check("bad_ready",     cfg.s_ready, 1);
    check("bad_done",      frames_done, 1);

    // Stalled data words to col 1 / frame 5 (bit 41)
    send(32'hFAB0_0105);
    cfg.s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(stall_w[i]);
      cfg.s_valid = 1'b0;
      if (i == 0)
        check("stall_row0_only", FrameData, 128'h44444444_33333333_22222222_A1A1A1A1);
      if (i < 3) begin
        for (int j = 0; j < 3; j++) begin
          tick();
          check($sformatf("stall_w%0d_idle%0d_strobe", i, j), FrameStrobe, 0);
          check($sformatf("stall_w%0d_idle%0d_busy", i, j), busy, 1);
        end
      end
    end
    check("stall_strobe", FrameStrobe, onehot(41));
    check("stall_fdata",  FrameData, stall_fd);
    tick();
    tick();
    check("stall_done", frames_done, 2);
    tick();

    // Reset during the first strobe cycle
    send(32'hFAB0_0203);
    send(32'h11111111);
    send(32'h22222222);
    send(32'h33333333);
    send(32'h44444444);
    cfg.s_valid = 1'b0;
    check("midrst_strobe_before", FrameStrobe, onehot(75));
    reset = 1'b1;
    #1;
    check("midrst_strobe", FrameStrobe, 0);
    check("midrst_fdata",  FrameData, 0);
    check("midrst_done",   frames_done, 0);
    check("midrst_busy",   busy, 0);
    check("midrst_ready",  cfg.s_ready, 0);
    tick();
    reset = 1'b0;
    tick();
    check("midrst_post_ready", cfg.s_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("midrst_post%0d_strobe", i), FrameStrobe, 0);
    end

    // Back-to-back frames: col 7/frame 35 then col 0/frame 0, valid always high
    send(32'hFAB0_0723);
    send(32'h01010101);
    send(32'h02020202);
    send(32'h03030303);
    send(32'h04040404);
    check("b2b1_strobe", FrameStrobe, onehot(287));
    check("b2b1_fdata",  FrameData, f1_fd);
    cfg.s_data = 32'hFAB0_0000;
    tick();
    check("b2b1_strobe_c1", FrameStrobe, onehot(287));
    tick();
    check("b2b1_gap_strobe", FrameStrobe, 0);
    check("b2b1_gap_fdata",  FrameData, f1_fd);
    tick();
    check("b2b_hdr_not_early", busy, 0);
    check("b2b_hdr_err",       err_hdr, 0);
    tick();
    check("b2b2_busy",  busy, 1);
    check("b2b2_fdata_held", FrameData, f1_fd);
    send(32'h50505050);
    check("b2b2_row0", FrameData, 128'h04040404_03030303_02020202_50505050);
    check("b2b2_strobe_gapless", FrameStrobe, 0);
    send(32'h60606060);
    send(32'h70707070);
    send(32'h80808080);
    cfg.s_valid = 1'b0;
    check("b2b2_strobe", FrameStrobe, onehot(0));
    check("b2b2_fdata",  FrameData, 128'h80808080_70707070_60606060_50505050);
    tick();
    tick();
    check("b2b_done", frames_done, 2);
    tick();

    // Counter wrap
    force dut.frames_done = 16'hFFFF;
    tick();
    release dut.frames_done;
    tick();
    check("wrap_preload", frames_done, 16'hFFFF);
    send(32'hFAB0_0001);
    send(32'hDEAD0001);
    send(32'hDEAD0002);
    send(32'hDEAD0003);
    send(32'hDEAD0004);
    cfg.s_valid = 1'b0;
    check("wrap_strobe", FrameStrobe, onehot(1));
    tick();
    tick();
    check("wrap_done", frames_done, 16'h0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
